// File: rtl/fir_pkg.sv
// Shared definitions for the FIR MAC sequencer: FSM encoding, default sizes
// and the accumulator width helper.
package fir_pkg;

   localparam int DEF_N    = 16;
   localparam int DEF_TAPS = 4;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_ACC   = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;
   localparam logic [2:0] S_OUT   = 3'd5;

   // Room for TAPS full-scale products without wrap-around.
   function automatic int acc_width(input int n, input int taps);
      return 2 * n + $clog2(taps);
   endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Handshake bundle between the FIR sequencer and the external multiplier.
interface fir_mac_sequencer_if
   import fir_pkg::*;
#(
   parameter int N = DEF_N
);
   logic           mul_lm;
   logic           mul_lq;
   logic           mul_s;
   logic [N-1:0]   mul_datam;
   logic [N-1:0]   mul_dataq;
   logic [2*N-1:0] mul_p;
   logic           mul_done;

   modport master (
      output mul_lm, mul_lq, mul_s, mul_datam, mul_dataq,
      input  mul_p, mul_done
   );

   modport slave (
      input  mul_lm, mul_lq, mul_s, mul_datam, mul_dataq,
      output mul_p, mul_done
   );
endinterface

// File: rtl/fir_delay_line.sv
// TAPS-deep sample history; x[0] is the newest sample, read by tap index.
module fir_delay_line
   import fir_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int TAPS = DEF_TAPS
)(
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    shift,
   input  logic [N-1:0]            din,
   input  logic [$clog2(TAPS)-1:0] idx,
   output logic [N-1:0]            dout
);
   logic [N-1:0] x [TAPS];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < TAPS; k++) x[k] <= '0;
      end else if (shift) begin
         x[0] <= din;
         for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
      end
   end

   assign dout = x[idx];
endmodule

// File: rtl/fir_mac_sequencer.sv
// Moore FSM that walks the taps, feeding an external multiplier through its
// load/start/done handshake and accumulating the products into one output.
module fir_mac_sequencer
   import fir_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int TAPS  = DEF_TAPS,
   parameter int ACC_W = acc_width(N, TAPS)
)(
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic [N-1:0]            sample_in,
   output logic                    busy,
   output logic [ACC_W-1:0]        y_out,
   output logic                    y_valid,
   output logic [$clog2(TAPS)-1:0] coef_addr,
   input  logic [N-1:0]            coef_data,
   fir_mac_sequencer_if.master     mul
);
   localparam int AW = $clog2(TAPS);
   localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [AW-1:0]    tap;
   logic [ACC_W-1:0] acc;
   logic [N-1:0]     xtap;
   logic             accept;

   assign accept = (state == S_IDLE) && start;

   fir_delay_line #(.N(N), .TAPS(TAPS)) u_dly (
      .clk   (clk),
      .rstn  (rstn),
      .shift (accept),
      .din   (sample_in),
      .idx   (tap),
      .dout  (xtap)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_RUN;
         S_RUN:   if (mul.mul_done) state_nxt = S_ACC;
         S_ACC:   state_nxt = S_DRAIN;
         S_DRAIN: if (!mul.mul_done) state_nxt = (tap == LAST_TAP) ? S_OUT : S_LOAD;
         S_OUT:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // y_out is loaded on entry to OUT so it is already valid while y_valid is high.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
         tap   <= '0;
         acc   <= '0;
         y_out <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            tap <= '0;
            acc <= '0;
         end
         if (state == S_ACC) acc <= acc + ACC_W'(mul.mul_p);
         if ((state == S_DRAIN) && !mul.mul_done) begin
            if (tap == LAST_TAP) y_out <= acc;
            else                 tap   <= tap + 1'b1;
         end
      end
   end

   assign busy          = (state != S_IDLE);
   assign y_valid       = (state == S_OUT);
   assign coef_addr     = tap;
   assign mul.mul_lm    = (state == S_LOAD);
   assign mul.mul_lq    = (state == S_LOAD);
   assign mul.mul_s     = (state == S_RUN);
   assign mul.mul_datam = xtap;
   assign mul.mul_dataq = coef_data;
endmodule
